// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction memory, the hazard/branch logic and decode.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, mem_data,
    output mem_addr, if_id_instr, if_id_npc, if_id_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, mem_data,
    input  mem_addr, if_id_instr, if_id_npc, if_id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed pc and the IF/ID register,
// with stall hold, branch redirect/flush and a count of captured instructions.
//
// state    | meaning
// BOOT     | first edge after reset, nothing captured
// RUN      | sequential fetch, one capture per edge
// STALL    | pc and IF/ID frozen until stall drops
// REDIRECT | pc already at target, IF/ID flushed for one cycle
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 128,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  // MEM_DEPTH is a power of two, so modulo arithmetic is just AW-bit wrap.
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STALL    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic [31:0]   instr_q;
  logic [31:0]   npc_q;
  logic          valid_q;
  logic [31:0]   count_q;
  logic          do_capture;
  logic          do_branch;

  assign pc_inc = pc + AW'(1);

  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_branch  = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN, S_STALL: begin
        if (bus.branch_taken) begin
          do_branch = 1'b1;
          state_nxt = S_REDIRECT;
        end else if (bus.stall) begin
          state_nxt = S_STALL;
        end else begin
          do_capture = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_REDIRECT: state_nxt = bus.stall ? S_STALL : S_RUN;
      default:    state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_BOOT;
      pc      <= RESET_PC[AW-1:0];
      instr_q <= NOP_WORD;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (do_branch) begin
        pc      <= bus.branch_target[AW-1:0];
        instr_q <= NOP_WORD;
        npc_q   <= 32'd0;
        valid_q <= 1'b0;
      end else if (do_capture) begin
        pc      <= pc_inc;
        instr_q <= bus.mem_data;
        npc_q   <= {{(32-AW){1'b0}}, pc_inc};
        valid_q <= 1'b1;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.mem_addr    = {{(32-AW){1'b0}}, pc};
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_npc   = npc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_count = count_q;

endmodule
